spi_sender: RTL and testbench

SPI_SENDER -- requirements
Module: spi_sender

---
 rtl/spi_sender.sv | 171 +++++++++++++++++
 tb/tb_spi_sender.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sender.sv
// SPI mode-0 byte sender with a small transmit FIFO.
// Bytes written into the FIFO are shifted out MSB first. CS_N stays low
// across back-to-back bytes while ENABLE is high and data is queued.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | CS_N high, SCLK low, waiting for ENABLE and a queued byte
// LOAD  | one cycle: FIFO head is in the shift register, CS_N low, MOSI = bit 7
// SHIFT | SCLK runs, one bit per SCLK period, new bit on each falling toggle
// DONE  | one cycle: byte finished, chain into LOAD or release CS_N
module spi_sender #(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic       S_CLK,
    input  logic       CLR,
    input  logic       SENDER_WRITE,
    input  logic [7:0] DATA_IN,
    input  logic       ENABLE,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_N,
    output logic       SENDER_BUFFER_SH_LD,
    output logic       SENDER_BUFFER_FULL_STATE,
    output logic       SENDER_FULL_STATE,
    output logic       SENDER_EMPTY_STATE,
    output logic       WRITE_OVERFLOW
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = 8;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [7:0]       head;
    logic [7:0]       shreg;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tog_cnt;
    logic             push;
    logic             pop;
    logic             drop;

    assign head = mem[rd_ptr];

    // Push/pop decode; a pop in the same cycle frees the slot a full-FIFO write needs.
    always_comb begin
        pop  = (state == LOAD);
        push = SENDER_WRITE && (!SENDER_FULL_STATE || pop);
        drop = SENDER_WRITE && SENDER_FULL_STATE && !pop;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO pointers, occupancy and registered status flags.
    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            SENDER_FULL_STATE  <= 1'b0;
            SENDER_EMPTY_STATE <= 1'b1;
            WRITE_OVERFLOW     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count              <= count_next;
            SENDER_FULL_STATE  <= (count_next == CNT_W'(DEPTH));
            SENDER_EMPTY_STATE <= (count_next == '0);
            WRITE_OVERFLOW     <= drop;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge S_CLK) begin
        if (!CLR && push) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    // Transfer sequencer with registered SPI and status outputs.
    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            state                    <= IDLE;
            SCLK                     <= 1'b0;
            MOSI                     <= 1'b0;
            CS_N                     <= 1'b1;
            SENDER_BUFFER_SH_LD      <= 1'b0;
            SENDER_BUFFER_FULL_STATE <= 1'b0;
            shreg                    <= '0;
            div_cnt                  <= '0;
            tog_cnt                  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ENABLE && !SENDER_EMPTY_STATE) begin
                        state                    <= LOAD;
                        CS_N                     <= 1'b0;
                        SENDER_BUFFER_FULL_STATE <= 1'b1;
                        shreg                    <= head;
                        MOSI                     <= head[7];
                    end
                end
                LOAD: begin
                    state               <= SHIFT;
                    SENDER_BUFFER_SH_LD <= 1'b1;
                    div_cnt             <= '0;
                    tog_cnt             <= '0;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        SCLK    <= ~SCLK;
                        tog_cnt <= tog_cnt + 4'd1;
                        // Data moves only on falling toggles so MOSI is stable at every rise.
                        if (SCLK) begin
                            shreg <= shreg << 1;
                            MOSI  <= shreg[6];
                        end
                        if (tog_cnt == 4'd15) begin
                            state                    <= DONE;
                            SENDER_BUFFER_SH_LD      <= 1'b0;
                            SENDER_BUFFER_FULL_STATE <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (ENABLE && !SENDER_EMPTY_STATE) begin
                        state                    <= LOAD;
                        SENDER_BUFFER_FULL_STATE <= 1'b1;
                        shreg                    <= head;
                        MOSI                     <= head[7];
                    end else begin
                        state <= IDLE;
                        CS_N  <= 1'b1;
                        MOSI  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    CS_N  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sender.sv
// Testbench for spi_sender: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-timeline reference model.
module tb_spi_sender;

    localparam int DEPTH       = 4;
    localparam int CLK_DIV     = 2;
    localparam int BYTE_CYC    = 2 + 16 * CLK_DIV;
    localparam int LAST_RISE_K = 2 + 15 * CLK_DIV;

    logic       S_CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       SENDER_WRITE = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       ENABLE = 1'b0;
    logic       SCLK;
    logic       MOSI;
    logic       CS_N;
    logic       SENDER_BUFFER_SH_LD;
    logic       SENDER_BUFFER_FULL_STATE;
    logic       SENDER_FULL_STATE;
    logic       SENDER_EMPTY_STATE;
    logic       WRITE_OVERFLOW;

    spi_sender #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .S_CLK                    (S_CLK),
        .CLR                      (CLR),
        .SENDER_WRITE             (SENDER_WRITE),
        .DATA_IN                  (DATA_IN),
        .ENABLE                   (ENABLE),
        .SCLK                     (SCLK),
        .MOSI                     (MOSI),
        .CS_N                     (CS_N),
        .SENDER_BUFFER_SH_LD      (SENDER_BUFFER_SH_LD),
        .SENDER_BUFFER_FULL_STATE (SENDER_BUFFER_FULL_STATE),
        .SENDER_FULL_STATE        (SENDER_FULL_STATE),
        .SENDER_EMPTY_STATE       (SENDER_EMPTY_STATE),
        .WRITE_OVERFLOW           (WRITE_OVERFLOW)
    );

    always #5 S_CLK = ~S_CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: queued bytes plus position inside the current byte
    // (0 = idle, 1 = load cycle, BYTE_CYC = done cycle).
    logic [7:0] m_q[$];
    logic [7:0] exp_sent[$];
    int         m_k = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;

    // Serial-side monitor state.
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;
    logic [7:0] rx_sh = 8'h00;
    int         rx_bits = 0;
    int         rx_count = 0;
    logic [7:0] rx_last = 8'h00;
    int         sclk_rises = 0;
    int         cs_rises = 0;
    int         cs_low_run = 0;
    int         last_cs_low_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic clr, input logic wr, input logic [7:0] din, input logic en);
        int   sz0;
        logic popped;
        if (clr) begin
            m_q.delete();
            m_k   = 0;
            m_ovf = 1'b0;
            return;
        end
        sz0    = m_q.size();
        popped = (m_k == 1);
        if (m_k == 0) begin
            if (en && sz0 > 0) begin
                m_k   = 1;
                m_cur = m_q[0];
            end
        end else if (m_k == 1) begin
            m_cur = m_q.pop_front();
            m_k   = 2;
        end else if (m_k == BYTE_CYC) begin
            if (en && sz0 > 0) begin
                m_k   = 1;
                m_cur = m_q[0];
            end else begin
                m_k = 0;
            end
        end else begin
            m_k++;
        end
        if (m_k == LAST_RISE_K) exp_sent.push_back(m_cur);
        m_ovf = 1'b0;
        if (wr) begin
            if (sz0 < DEPTH || popped) m_q.push_back(din);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic e_sh;
        logic e_bf;
        logic e_sclk;
        int   j;
        int   bi;
        e_sh   = (m_k >= 2 && m_k <= BYTE_CYC - 1);
        e_bf   = (m_k >= 1 && m_k <= BYTE_CYC - 1);
        e_sclk = 1'b0;
        j      = 0;
        if (e_sh) begin
            j      = m_k - 2;
            e_sclk = ((j / CLK_DIV) % 2) == 1;
        end
        check("cs_n", 32'(CS_N), 32'(m_k == 0));
        check("sh_ld", 32'(SENDER_BUFFER_SH_LD), 32'(e_sh));
        check("buffer_full", 32'(SENDER_BUFFER_FULL_STATE), 32'(e_bf));
        check("sclk", 32'(SCLK), 32'(e_sclk));
        check("fifo_full", 32'(SENDER_FULL_STATE), 32'(m_q.size() == DEPTH));
        check("fifo_empty", 32'(SENDER_EMPTY_STATE), 32'(m_q.size() == 0));
        check("write_overflow", 32'(WRITE_OVERFLOW), 32'(m_ovf));
        if (m_k == 0) begin
            check("mosi_idle", 32'(MOSI), 32'd0);
        end else if (m_k == 1) begin
            check("mosi_load", 32'(MOSI), 32'(m_cur[7]));
        end else if (e_sh) begin
            bi = 7 - j / (2 * CLK_DIV);
            check("mosi_shift", 32'(MOSI), 32'(m_cur[bi]));
        end
    endtask

    task automatic monitor();
        if (SCLK && !prev_sclk) begin
            sclk_rises++;
            if (!CS_N) begin
                rx_sh = {rx_sh[6:0], MOSI};
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_bits = 0;
                    rx_count++;
                    rx_last = rx_sh;
                    check("rx_expected", 32'(exp_sent.size() > 0), 32'd1);
                    if (exp_sent.size() > 0) check("rx_byte", 32'(rx_sh), 32'(exp_sent.pop_front()));
                end
            end
        end
        if (CS_N) rx_bits = 0;
        if (CS_N && !prev_cs) cs_rises++;
        if (!CS_N) begin
            cs_low_run++;
        end else begin
            if (!prev_cs) last_cs_low_run = cs_low_run;
            cs_low_run = 0;
        end
        prev_sclk = SCLK;
        prev_cs   = CS_N;
    endtask

    task automatic cycle(input logic clr, input logic wr, input logic [7:0] din, input logic en);
        CLR          = clr;
        SENDER_WRITE = wr;
        DATA_IN      = din;
        ENABLE       = en;
        @(posedge S_CLK);
        #1;
        cyc++;
        model_step(clr, wr, din, en);
        check_outputs();
        monitor();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         r0;
        int         c0;
        int         x0;
        logic       en;
        logic       clr;
        logic       wr;
        logic [7:0] b;

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("reset_cs_n", 32'(CS_N), 32'd1);
        check("reset_empty", 32'(SENDER_EMPTY_STATE), 32'd1);

        // Single byte 0xA5.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("a5_cs_low_after_write", 32'(CS_N), 32'd0);
        repeat (39) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("a5_rx_byte", 32'(rx_last), 32'hA5);
        check("a5_load_to_done_cycles", 32'(last_cs_low_run), 32'd34);
        check("a5_empty_after", 32'(SENDER_EMPTY_STATE), 32'd1);
        check("a5_cs_high_after", 32'(CS_N), 32'd1);

        // Fill, overflow, then back-to-back drain.
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        check("fill_full", 32'(SENDER_FULL_STATE), 32'd1);
        cycle(1'b0, 1'b1, 8'h05, 1'b0);
        check("fill_overflow_pulse", 32'(WRITE_OVERFLOW), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("fill_overflow_clear", 32'(WRITE_OVERFLOW), 32'd0);
        check("fill_still_full", 32'(SENDER_FULL_STATE), 32'd1);
        c0 = cs_rises;
        x0 = rx_count;
        repeat (4 * BYTE_CYC + 10) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("burst_rx_count", 32'(rx_count - x0), 32'd4);
        check("burst_cs_rises", 32'(cs_rises - c0), 32'd1);
        check("burst_last_byte", 32'(rx_last), 32'h04);

        // Write on the pop cycle of a full FIFO.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'h14, 1'b1);
        check("popwr_no_overflow", 32'(WRITE_OVERFLOW), 32'd0);
        check("popwr_full_kept", 32'(SENDER_FULL_STATE), 32'd1);
        repeat (5 * BYTE_CYC + 10) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("popwr_last_byte", 32'(rx_last), 32'h14);

        // Clear in the middle of 0xFF with another byte queued.
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        r0 = sclk_rises;
        n  = 0;
        while (sclk_rises - r0 < 3 && n < 200) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            n++;
        end
        check("clr_third_rise_seen", 32'(sclk_rises - r0 >= 3), 32'd1);
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        check("clr_cs_n", 32'(CS_N), 32'd1);
        check("clr_sclk", 32'(SCLK), 32'd0);
        check("clr_empty", 32'(SENDER_EMPTY_STATE), 32'd1);
        r0 = sclk_rises;
        repeat (20) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_no_more_sclk", 32'(sclk_rises - r0), 32'd0);

        // ENABLE dropped mid-byte: current byte finishes, queued byte waits.
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 1'b1, 8'h55, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end while (!CS_N && n < 100);
        check("endrop_idle", 32'(CS_N), 32'd1);
        check("endrop_rx_byte", 32'(rx_last), 32'h3C);
        check("endrop_not_empty", 32'(SENDER_EMPTY_STATE), 32'd0);
        repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("endrop_stays_idle", 32'(CS_N), 32'd1);
        repeat (BYTE_CYC + 6) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("endrop_resume_byte", 32'(rx_last), 32'h55);

        // Eight spaced bytes so both pointers wrap.
        x0 = rx_count;
        b  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            cycle(1'b0, 1'b1, b, 1'b1);
            repeat (39) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("wrap_rx_count", 32'(rx_count - x0), 32'd8);
        check("wrap_last_byte", 32'(rx_last), 32'(b));

        // Randomized traffic with ENABLE toggling and occasional clears.
        en = 1'b1;
        repeat (2000) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            clr = ($urandom_range(0, 399) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            cycle(clr, wr, 8'($urandom), en);
        end
        repeat ((DEPTH + 2) * BYTE_CYC + 20) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("final_all_bytes_seen", 32'(exp_sent.size()), 32'd0);
        check("final_empty", 32'(SENDER_EMPTY_STATE), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
